// File: rtl/bus_mem_responder_if.sv
// Request/response bundle between a bus master and bus_mem_responder.
// Signal names keep the responder's i_/o_ view so both ends read the same way.
interface bus_mem_responder_if;
  logic        i_start;
  logic        i_write;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_bus_DV;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_busy;

  modport slave (
    input  i_start, i_write, i_addr, i_wdata, i_size, i_unsigned,
    output o_bus_DV, o_rdata, o_err, o_busy
  );

  modport master (
    output i_start, i_write, i_addr, i_wdata, i_size, i_unsigned,
    input  o_bus_DV, o_rdata, o_err, o_busy
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Single-port word memory answering one byte/half/word load or store at a time,
// with a fixed number of wait cycles before the one-cycle response pulse.
module bus_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  bus_mem_responder_if.slave    bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        write_q, unsigned_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        capture;
  logic        enter_resp;
  logic        req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        misaligned, size_err, range_err, req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]  lane_en;
  logic [31:0] wdata_sh;
  logic [31:0] rd_word, rd_sh, load_val;
  logic        mem_we;

  assign capture = (state_q == S_IDLE) && bus.i_start;

  // With no wait cycles the capture edge is also the edge entering RESPOND, so the
  // memory access must see the live inputs there and the captured copy otherwise.
  assign req_write    = (state_q == S_IDLE) ? bus.i_write    : write_q;
  assign req_unsigned = (state_q == S_IDLE) ? bus.i_unsigned : unsigned_q;
  assign req_addr     = (state_q == S_IDLE) ? bus.i_addr     : addr_q;
  assign req_wdata    = (state_q == S_IDLE) ? bus.i_wdata    : wdata_q;
  assign req_size     = (state_q == S_IDLE) ? bus.i_size     : size_q;

  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign size_err   = (req_size == SZ_RSVD);
  assign range_err  = ({1'b0, req_addr} >= MEM_BYTES);
  assign req_err    = misaligned || size_err || range_err;

  assign word_idx = req_addr[AW+1:2];

  // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = S_RESPOND;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESPOND;
          cnt_d   = 4'd0;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESPOND) && (state_q != S_RESPOND);

  always_comb begin
    lane_en = 4'b0000;
    unique case (req_size)
      SZ_BYTE: lane_en = 4'b0001 << req_addr[1:0];
      SZ_HALF: lane_en = 4'b0011 << req_addr[1:0];
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
  // Gated by i_rst_n so a clock edge during reset can never commit a store.
  assign mem_we   = enter_resp && req_write && !req_err && i_rst_n;

  assign rd_word = mem[word_idx];
  assign rd_sh   = rd_word >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_val = rd_word;
    unique case (req_size)
      SZ_BYTE: load_val = req_unsigned ? {24'h0, rd_sh[7:0]}
                                       : {{24{rd_sh[7]}}, rd_sh[7:0]};
      SZ_HALF: load_val = req_unsigned ? {16'h0, rd_sh[15:0]}
                                       : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = req_err;
      if (req_err)        rdata_d = 32'h0;
      else if (!req_write) rdata_d = load_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'b00;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        write_q    <= bus.i_write;
        unsigned_q <= bus.i_unsigned;
        addr_q     <= bus.i_addr;
        wdata_q    <= bus.i_wdata;
        size_q     <= bus.i_size;
      end
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; contents are
  // undefined until written.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.o_bus_DV = (state_q == S_RESPOND);
  assign bus.o_err    = (state_q == S_RESPOND) && err_q;
  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_rdata  = rdata_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for the main function and reset abort,
// and a WAIT_CYCLES=0 instance for the back-to-back/busy behaviour.
module tb_bus_mem_responder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bus_mem_responder_if bus2 ();
  bus_mem_responder_if bus0 ();

  bus_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut2 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus2)
  );

  bus_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit fast, input bit st, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input bit u);
    if (fast) begin
      bus0.i_start = st; bus0.i_write = w; bus0.i_addr = a;
      bus0.i_wdata = wd; bus0.i_size = sz; bus0.i_unsigned = u;
    end else begin
      bus2.i_start = st; bus2.i_write = w; bus2.i_addr = a;
      bus2.i_wdata = wd; bus2.i_size = sz; bus2.i_unsigned = u;
    end
  endtask

  // Issue one request, measure latency from the capture edge, return the response.
  task automatic do_req(input bit fast, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input bit u,
                        input string nm, output logic [31:0] rd, output logic er);
    int   lat;
    int   exp_lat;
    bit   got;
    logic dv, bsy;
    exp_lat = fast ? 1 : 3;
    rd = 32'h0; er = 1'b0;
    @(negedge clk);
    drive(fast, 1'b1, w, a, wd, sz, u);
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (lat == 0) begin
        if (fast) bus0.i_start = 1'b0; else bus2.i_start = 1'b0;
      end
      lat++;
      if (fast) begin dv = bus0.o_bus_DV; bsy = bus0.o_busy; rd = bus0.o_rdata; er = bus0.o_err; end
      else      begin dv = bus2.o_bus_DV; bsy = bus2.o_busy; rd = bus2.o_rdata; er = bus2.o_err; end
      if (dv) got = 1'b1;
      else begin
        n_cmp++;
        if (bsy !== 1'b1 || er !== 1'b0) begin
          n_bad++;
          $display("FAIL %s wait: busy=%b err=%b, required busy=1 err=0", nm, bsy, er);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: no o_bus_DV within 20 cycles", nm);
    end else if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d, required %0d", nm, lat, exp_lat);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus2.o_bus_DV, bus2.o_err, bus2.o_busy} !== 3'b000 || bus2.o_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: dv/err/busy=%b%b%b rdata=%h, required 000 and 0",
               bus2.o_bus_DV, bus2.o_err, bus2.o_busy, bus2.o_rdata);
    end
    n_cmp++;
    if ({bus0.o_bus_DV, bus0.o_busy} !== 2'b00 || bus0.o_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state_fast: dv/busy=%b%b rdata=%h, required 00 and 0",
               bus0.o_bus_DV, bus0.o_busy, bus0.o_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, "sw_0x10", rd, er);
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL sw_0x10 err: got %b, required 0", er); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "lw_0x10", rd, er);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lw_0x10: rdata=%h err=%b, required deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er;
    logic [31:0] exp_v [5];
    logic [31:0] adr   [5];
    logic [1:0]  sz    [5];
    bit          uns   [5];
    exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h00007F01, 32'h0000007F};
    adr   = '{32'h23, 32'h23, 32'h22, 32'h20, 32'h21};
    sz    = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    uns   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_req(1'b0, 1'b1, 32'h20, 32'h80817F01, 2'b10, 1'b0, "sw_0x20", rd, er);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_keeps_rdata: rdata=%h, required deadbeef", rd);
    end
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 1'b0, adr[i], 32'h0, sz[i], uns[i], "subword_load", rd, er);
      n_cmp++;
      if (rd !== exp_v[i] || er !== 1'b0) begin
        n_bad++;
        $display("FAIL subword_load[%0d] addr=%h: rdata=%h err=%b, required %h err=0",
                 i, adr[i], rd, er, exp_v[i]);
      end
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, "sw_base", rd, er);
    do_req(1'b0, 1'b1, 32'h21, 32'h000000AA, 2'b00, 1'b0, "sb_0x21", rd, er);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "lw_after_sb", rd, er);
    n_cmp++;
    if (rd !== 32'h1122AA44) begin
      n_bad++;
      $display("FAIL byte_store: rdata=%h, required 1122aa44", rd);
    end
    do_req(1'b0, 1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0, "sh_0x22", rd, er);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "lw_after_sh", rd, er);
    n_cmp++;
    if (rd !== 32'hBEEFAA44) begin
      n_bad++;
      $display("FAIL half_store: rdata=%h, required beefaa44", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er;
    bit          ew  [5];
    logic [31:0] ea  [5];
    logic [1:0]  esz [5];
    ew  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ea  = '{32'h22, 32'h21, 32'h20, 32'h1000, 32'h1000};
    esz = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, ew[i], ea[i], 32'h5555FFFF, esz[i], 1'b0, "err_access", rd, er);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        n_bad++;
        $display("FAIL err_access[%0d] addr=%h: err=%b rdata=%h, required err=1 rdata=0",
                 i, ea[i], er, rd);
      end
      @(negedge clk);
      n_cmp++;
      if (bus2.o_err !== 1'b0 || bus2.o_bus_DV !== 1'b0) begin
        n_bad++;
        $display("FAIL err_after_dv[%0d]: err=%b dv=%b, required 0 0", i, bus2.o_err, bus2.o_bus_DV);
      end
    end
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "lw_after_errs", rd, er);
    n_cmp++;
    if (rd !== 32'hBEEFAA44 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL mem_unchanged_by_errors: rdata=%h err=%b, required beefaa44 err=0", rd, er);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, "sw_prior", rd, er);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus2.i_start = 1'b0;
    n_cmp++;
    if (bus2.o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_wait: busy=%b, required 1", bus2.o_busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus2.o_busy !== 1'b0 || bus2.o_bus_DV !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_async: busy=%b dv=%b, required 0 0", bus2.o_busy, bus2.o_bus_DV);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus2.o_bus_DV !== 1'b0 || bus2.o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_pulse[%0d]: dv=%b busy=%b, required 0 0", i, bus2.o_bus_DV, bus2.o_busy);
      end
    end
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, "lw_after_abort", rd, er);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL aborted_store: rdata=%h, required cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er;
    do_req(1'b1, 1'b1, 32'h0, 32'h01020304, 2'b10, 1'b0, "fast_sw0", rd, er);
    do_req(1'b1, 1'b1, 32'h4, 32'h0A0B0C0D, 2'b10, 1'b0, "fast_sw4", rd, er);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus0.o_bus_DV !== 1'b1 || bus0.o_rdata !== 32'h01020304) begin
      n_bad++;
      $display("FAIL hold_first: dv=%b rdata=%h, required 1 01020304", bus0.o_bus_DV, bus0.o_rdata);
    end
    bus0.i_addr = 32'h4;
    @(negedge clk);
    n_cmp++;
    if (bus0.o_bus_DV !== 1'b0 || bus0.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle_gap: dv=%b busy=%b, required 0 0", bus0.o_bus_DV, bus0.o_busy);
    end
    bus0.i_addr = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (bus0.o_bus_DV !== 1'b1 || bus0.o_rdata !== 32'h01020304) begin
      n_bad++;
      $display("FAIL addr_in_respond_ignored: dv=%b rdata=%h, required 1 01020304",
               bus0.o_bus_DV, bus0.o_rdata);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus0.o_bus_DV !== 1'(k % 2)) begin
        n_bad++;
        $display("FAIL hold_pulse[%0d]: dv=%b, required %0d", k, bus0.o_bus_DV, k % 2);
      end
    end
    bus0.i_addr = 32'h4;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus0.o_bus_DV !== 1'b1 || bus0.o_rdata !== 32'h0A0B0C0D) begin
      n_bad++;
      $display("FAIL hold_new_addr: dv=%b rdata=%h, required 1 0a0b0c0d", bus0.o_bus_DV, bus0.o_rdata);
    end
    bus0.i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus0.o_bus_DV !== 1'b0) begin
        n_bad++;
        $display("FAIL release_start[%0d]: dv=%b, required 0", k, bus0.o_bus_DV);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_word();
    test_subword();
    test_byte_store();
    test_errors();
    test_reset_mid_store();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
